// File: rtl/error_flag_if.sv
// Sample/flag bus between the error source and error_flag_generator.
// The master side drives samples and start; the slave side publishes flags and status.
interface error_flag_if #(
  parameter int NUM_OUTPUTS = 34,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 6,
  parameter int EPOCH_W     = 16
);
  logic                   start;
  logic [DATA_W-1:0]      threshold;
  logic                   err_valid;
  logic [IDX_W-1:0]       err_index;
  logic [DATA_W-1:0]      err_value;
  logic [NUM_OUTPUTS-1:0] SQUARED_ERROR;
  logic                   flags_valid;
  logic                   busy;
  logic                   sweep_error;
  logic [EPOCH_W-1:0]     epoch_count;
  logic                   epoch_cap_hit;

  modport master (
    output start, threshold, err_valid, err_index, err_value,
    input  SQUARED_ERROR, flags_valid, busy, sweep_error, epoch_count, epoch_cap_hit
  );

  modport slave (
    input  start, threshold, err_valid, err_index, err_value,
    output SQUARED_ERROR, flags_valid, busy, sweep_error, epoch_count, epoch_cap_hit
  );
endinterface

// File: rtl/error_flag_generator.sv
// Collects an in-order sweep of squared-error samples, flags outputs above threshold
// and publishes the flag vector. Optional epoch cap enabled by macro EPOCH_CAP_EN.
module error_flag_generator #(
  parameter int NUM_OUTPUTS = 34,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 6,
  parameter int MAX_EPOCHS  = 1000,
  parameter int EPOCH_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  error_flag_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

  state_t                 state_reg, state_next;
  logic [NUM_OUTPUTS-1:0] work_reg, work_next;
  logic [NUM_OUTPUTS-1:0] sq_reg, sq_next;
  logic [NUM_OUTPUTS-1:0] hit_vec;
  logic [IDX_W-1:0]       expected_reg, expected_next;
  logic [DATA_W-1:0]      thr_reg, thr_next;
  logic                   fv_reg, fv_next;
  logic                   serr_reg, serr_next;
  logic                   accept;
  logic                   over;
  logic                   force_zero;

  // start takes priority over a same-cycle sample, so it blocks acceptance
  assign accept = (state_reg == COLLECT) && bus.err_valid && !bus.start &&
                  (bus.err_index == expected_reg);
  assign over   = bus.err_value > thr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_hit
      assign hit_vec[gi] = accept && (expected_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef EPOCH_CAP_EN
  logic [EPOCH_W-1:0] epoch_reg;
  logic               cap_reg;

  assign force_zero = cap_reg || (epoch_reg == EPOCH_W'(MAX_EPOCHS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch_reg <= '0;
      cap_reg   <= 1'b0;
    end else if (state_reg == PUBLISH && !cap_reg) begin
      epoch_reg <= epoch_reg + 1'b1;
      if (epoch_reg == EPOCH_W'(MAX_EPOCHS - 1))
        cap_reg <= 1'b1;
    end
  end

  assign bus.epoch_count   = epoch_reg;
  assign bus.epoch_cap_hit = cap_reg;
`else
  assign force_zero        = 1'b0;
  assign bus.epoch_count   = '0;
  // constant low for any legal cap value; the cap has no effect in this build
  assign bus.epoch_cap_hit = (MAX_EPOCHS < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    work_next     = work_reg;
    expected_next = expected_reg;
    thr_next      = thr_reg;
    sq_next       = sq_reg;
    fv_next       = 1'b0;
    serr_next     = serr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next    = COLLECT;
          work_next     = '0;
          expected_next = '0;
          serr_next     = 1'b0;
          thr_next      = bus.threshold;
        end
      end
      COLLECT: begin
        if (bus.start) begin
          work_next     = '0;
          expected_next = '0;
          serr_next     = 1'b0;
          thr_next      = bus.threshold;
        end else if (bus.err_valid) begin
          if (accept) begin
            work_next     = (work_reg & ~hit_vec) | (hit_vec & {NUM_OUTPUTS{over}});
            expected_next = expected_reg + 1'b1;
            if (expected_reg == LAST_IDX)
              state_next = PUBLISH;
          end else begin
            serr_next = 1'b1;
          end
        end
      end
      PUBLISH: begin
        sq_next    = force_zero ? '0 : work_reg;
        fv_next    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // published vector resets to all ones so nothing reads as converged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg     <= '0;
      expected_reg <= '0;
      thr_reg      <= '0;
      sq_reg       <= '1;
      fv_reg       <= 1'b0;
      serr_reg     <= 1'b0;
    end else begin
      work_reg     <= work_next;
      expected_reg <= expected_next;
      thr_reg      <= thr_next;
      sq_reg       <= sq_next;
      fv_reg       <= fv_next;
      serr_reg     <= serr_next;
    end
  end

  assign bus.SQUARED_ERROR = sq_reg;
  assign bus.flags_valid   = fv_reg;
  assign bus.sweep_error   = serr_reg;
  assign bus.busy          = (state_reg != IDLE);

endmodule

// File: doc/error_flag_generator.md
ERROR_FLAG_GENERATOR -- requirements
Module: error_flag_generator

Interface
REQ-001 Parameter NUM_OUTPUTS, default 34: number of network outputs, one flag bit per output.
REQ-002 Parameter DATA_W, default 32: width of squared-error samples and threshold, unsigned.
REQ-003 Parameter IDX_W, default 6: width of the sample index.
REQ-004 Parameter MAX_EPOCHS, default 1000: epoch cap, used only when EPOCH_CAP_EN is defined.
REQ-005 Parameter EPOCH_W, default 16: epoch counter width.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse: begin a new sweep, latch threshold.
REQ-009 threshold  input  DATA_W  convergence threshold, sampled only on accepted start.
REQ-010 err_valid  input  1  squared-error sample present this cycle.
REQ-011 err_index  input  IDX_W  output index of the sample.
REQ-012 err_value  input  DATA_W  squared-error value.
REQ-013 SQUARED_ERROR  output  NUM_OUTPUTS  published flag vector; bit i = 1 means output i not converged.
REQ-014 flags_valid  output  1  one-cycle pulse when SQUARED_ERROR is updated.
REQ-015 busy  output  1  high while a sweep is in progress.
REQ-016 sweep_error  output  1  sticky: out-of-order sample seen in current sweep.
REQ-017 epoch_count  output  EPOCH_W  number of published sweeps.
REQ-018 epoch_cap_hit  output  1  sticky: epoch cap reached.

Function
REQ-019 FSM states IDLE, COLLECT, PUBLISH; IDLE after reset.
REQ-020 IDLE: start -> COLLECT; clear working vector, expected index = 0, clear sweep_error, latch threshold; err_valid ignored.
REQ-021 COLLECT: err_valid with err_index == expected -> working bit[err_index] = (err_value > latched threshold), expected + 1.
REQ-022 err_value == threshold yields flag 0 (converged).
REQ-023 COLLECT: err_valid with err_index != expected -> sample discarded, sweep_error = 1, expected unchanged, stay COLLECT.
REQ-024 COLLECT: accepted sample with index NUM_OUTPUTS-1 -> PUBLISH.
REQ-025 PUBLISH (one cycle): SQUARED_ERROR = working vector including last bit, flags_valid = 1, -> IDLE; latency last sample accepted at edge N, SQUARED_ERROR/flags_valid visible after edge N+1.
REQ-026 start in COLLECT aborts sweep and restarts as in REQ-020; same-cycle err_valid discarded; SQUARED_ERROR unchanged.
REQ-027 start in PUBLISH ignored; start and err_valid together in IDLE: start wins, sample discarded.
REQ-028 busy = 1 in COLLECT and PUBLISH, 0 in IDLE.
REQ-029 SQUARED_ERROR holds its value between publishes; indices >= NUM_OUTPUTS never accepted (always out-of-order).

Reset
REQ-030 rst asserted at any time, including mid-sweep, forces IDLE within the same cycle, discards the working vector.
REQ-031 Reset values: SQUARED_ERROR all ones (never reads as converged), flags_valid 0, busy 0, sweep_error 0, epoch_count 0, epoch_cap_hit 0, latched threshold 0.

Configuration
REQ-032 Macro EPOCH_CAP_EN defined: each PUBLISH increments epoch_count, saturating at MAX_EPOCHS; the PUBLISH that brings epoch_count to MAX_EPOCHS forces SQUARED_ERROR to all zeros and sets epoch_cap_hit; all later publishes also output all zeros; only rst clears.
REQ-033 EPOCH_CAP_EN undefined: no counter logic; epoch_count tied 0, epoch_cap_hit tied 0, SQUARED_ERROR always the compared vector.

Verification
REQ-034 Reset, no stimulus -> SQUARED_ERROR = 34'h3_FFFF_FFFF, flags_valid 0, busy 0.
REQ-035 start, threshold=100; indices 0..33 in order, value 50 except index 7 = 200 -> one cycle after index 33, SQUARED_ERROR = 34'h80, flags_valid one cycle, busy 0.
REQ-036 start, threshold=100; all values exactly 100 -> SQUARED_ERROR = 0 published.
REQ-037 start; indices 0,1,3 -> sweep_error 1, index 3 discarded; continue 2..33 -> normal publish, sweep_error stays 1 until next start.
REQ-038 start; indices 0..20; start again; 0..33 all 500, threshold 100 -> only one flags_valid, SQUARED_ERROR all ones; rst at index 10 of a sweep -> IDLE, no flags_valid.
REQ-039 EPOCH_CAP_EN, MAX_EPOCHS=3; three sweeps all values 500, threshold 100 -> publishes 1,2 all ones, publish 3 all zeros, epoch_count 3, epoch_cap_hit 1.
